// File: rtl/alu_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_instr_sequencer
// Purpose  : T-state control unit for the phase-1 datapath. It fetches one
//            instruction, decodes it from IR, and sequences ALU or HI/LO ops.
// Revision : 1.0  initial release
// ============================================================================
module alu_instr_sequencer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        ZLowOut,
  output logic        ZHighOut,
  output logic        LOin,
  output logic        HIin,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [4:0]  alu_op,
  output logic        done,
  output logic        illegal,
  output logic        bus_err,
  output logic        halted
);

  localparam logic [4:0] c_OP_ADD  = 5'b00011;
  localparam logic [4:0] c_OP_SUB  = 5'b00100;
  localparam logic [4:0] c_OP_AND  = 5'b00101;
  localparam logic [4:0] c_OP_OR   = 5'b00110;
  localparam logic [4:0] c_OP_SHR  = 5'b00111;
  localparam logic [4:0] c_OP_SHL  = 5'b01000;
  localparam logic [4:0] c_OP_MUL  = 5'b01111;
  localparam logic [4:0] c_OP_DIV  = 5'b10000;
  localparam logic [4:0] c_OP_NEG  = 5'b10001;
  localparam logic [4:0] c_OP_NOT  = 5'b10010;
  localparam logic [4:0] c_OP_NOP  = 5'b11010;
  localparam logic [4:0] c_OP_HALT = 5'b11011;

  localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_DONE = 4'd8,
    S_ILL  = 4'd9,
    S_HALT = 4'd10
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_wait_cnt;
  logic       r_bus_err;

  logic [4:0] w_op;
  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  logic       w_is_alu3;
  logic       w_is_unary;
  logic       w_is_muldiv;
  logic       w_is_exec;
  logic       w_timeout;
  logic       w_unused;

  assign w_op     = ir[31:27];
  assign w_ra     = ir[26:23];
  assign w_rb     = ir[22:19];
  assign w_rc     = ir[18:15];
  assign w_unused = ^ir[14:0];

  always_comb begin
    w_is_alu3   = 1'b0;
    w_is_unary  = 1'b0;
    w_is_muldiv = 1'b0;
    case (w_op)
      c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SHR, c_OP_SHL: w_is_alu3 = 1'b1;
      c_OP_NEG, c_OP_NOT:                                       w_is_unary = 1'b1;
      c_OP_MUL, c_OP_DIV:                                       w_is_muldiv = 1'b1;
      default: ;
    endcase
  end

  assign w_is_exec = w_is_alu3 | w_is_unary | w_is_muldiv;
  assign w_timeout = (r_state == S_T1) && !mem_ready && (r_wait_cnt == c_WAIT_LAST);

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_bus_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_T1) && !mem_ready) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  // Opcode class is resolved as the sequencer leaves T2, so the IR must hold
  // the fetched word by the end of that cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (run) w_next = S_T0;
      S_T0:   w_next = S_T1;
      S_T1: begin
        if (mem_ready)      w_next = S_T2;
        else if (w_timeout) w_next = S_HALT;
      end
      S_T2: begin
        if (w_op == c_OP_NOP)       w_next = S_DONE;
        else if (w_op == c_OP_HALT) w_next = S_HALT;
        else if (w_is_exec)         w_next = S_T3;
        else                        w_next = S_ILL;
      end
      S_T3:          w_next = S_T4;
      S_T4:          w_next = S_T5;
      S_T5:          w_next = w_is_muldiv ? S_T6 : S_DONE;
      S_T6:          w_next = S_DONE;
      S_DONE, S_ILL: w_next = run ? S_T0 : S_IDLE;
      S_HALT:        w_next = S_HALT;
      default:       w_next = S_IDLE;
    endcase
  end

  always_comb begin
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    ZLowIn   = 1'b0;
    ZHighIn  = 1'b0;
    ZLowOut  = 1'b0;
    ZHighOut = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    alu_op   = '0;
    done     = 1'b0;
    illegal  = 1'b0;
    halted   = 1'b0;
    case (r_state)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        ZLowIn = 1'b1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        Rout   = 16'd1 << w_rb;
        Yin    = 1'b1;
        alu_op = w_op;
      end
      S_T4: begin
        // Unary ops take their single operand from rb on the bus.
        Rout    = w_is_unary ? (16'd1 << w_rb) : (16'd1 << w_rc);
        ZLowIn  = 1'b1;
        ZHighIn = w_is_muldiv;
        alu_op  = w_op;
      end
      S_T5: begin
        ZLowOut = 1'b1;
        if (w_is_muldiv) LOin = 1'b1;
        else             Rin  = 16'd1 << w_ra;
      end
      S_T6: begin
        ZHighOut = 1'b1;
        HIin     = 1'b1;
      end
      S_DONE: done = 1'b1;
      S_ILL: begin
        done    = 1'b1;
        illegal = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign bus_err = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_instr_sequencer
// Purpose  : Self-checking bench: per-cycle strobe vectors plus reset, halt,
//            back-to-back and memory-timeout sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_instr_sequencer;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        run;
  logic [31:0] ir;
  logic        mem_ready;
  logic        PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin;
  logic        ZLowIn, ZHighIn, ZLowOut, ZHighOut, LOin, HIin;
  logic [15:0] Rin, Rout;
  logic [4:0]  alu_op;
  logic        done, illegal, bus_err, halted;

  int n_checks = 0;
  int n_errors = 0;

  // Strobe order: PCout MARin IncPC Read MDRin MDRout IRin Yin ZLowIn ZHighIn ZLowOut ZHighOut LOin HIin
  localparam logic [13:0] c_T0  = 14'b11100000100000;
  localparam logic [13:0] c_T1  = 14'b00011000000000;
  localparam logic [13:0] c_T2  = 14'b00000110000000;
  localparam logic [13:0] c_T3  = 14'b00000001000000;
  localparam logic [13:0] c_T4A = 14'b00000000100000;
  localparam logic [13:0] c_T4M = 14'b00000000110000;
  localparam logic [13:0] c_T5A = 14'b00000000001000;
  localparam logic [13:0] c_T5M = 14'b00000000001010;
  localparam logic [13:0] c_T6  = 14'b00000000000101;

  alu_instr_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clock(clock), .clear_n(clear_n), .run(run), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .LOin(LOin), .HIin(HIin),
    .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .done(done), .illegal(illegal),
    .bus_err(bus_err), .halted(halted)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] ir;
    logic [7:0]  wait_n;
    logic        noise;
    logic [7:0]  base;
    logic [13:0] s_t4;
    logic [13:0] s_t5;
    logic [15:0] rout_t3;
    logic [15:0] rout_t4;
    logic [15:0] rin_t5;
    logic [4:0]  alu;
    logic        ill;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [31:0] mk(logic [4:0] op, logic [3:0] ra, logic [3:0] rb, logic [3:0] rc);
    return {op, ra, rb, rc, 15'h0};
  endfunction

  function automatic vec_t mkv(logic [31:0] i, int w, bit nz, int b, logic [13:0] s4, logic [13:0] s5,
                               logic [15:0] r3, logic [15:0] r4, logic [15:0] ri, logic [4:0] a, bit il);
    vec_t v;
    v.ir = i; v.wait_n = 8'(w); v.noise = nz; v.base = 8'(b);
    v.s_t4 = s4; v.s_t5 = s5; v.rout_t3 = r3; v.rout_t4 = r4; v.rin_t5 = ri;
    v.alu = a; v.ill = il;
    return v;
  endfunction

  function automatic logic [52:0] pk(logic [13:0] s, logic [15:0] ri, logic [15:0] ro,
                                     logic [4:0] a, logic d, logic il);
    return {s, ri, ro, a, d, il};
  endfunction

  function automatic logic [52:0] word();
    return pk({PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin,
               ZLowIn, ZHighIn, ZLowOut, ZHighOut, LOin, HIin}, Rin, Rout, alu_op, done, illegal);
  endfunction

  function automatic logic [52:0] expect_word(vec_t v, int k);
    int dc;
    int j;
    dc = int'(v.base) + int'(v.wait_n);
    if (k > dc)  return '0;
    if (k == dc) return pk('0, '0, '0, '0, 1'b1, v.ill);
    if (k == 1)  return pk(c_T0, '0, '0, '0, 1'b0, 1'b0);
    if (k <= 2 + int'(v.wait_n)) return pk(c_T1, '0, '0, '0, 1'b0, 1'b0);
    j = k - int'(v.wait_n);
    case (j)
      3:       return pk(c_T2, '0, '0, '0, 1'b0, 1'b0);
      4:       return pk(c_T3, '0, v.rout_t3, v.alu, 1'b0, 1'b0);
      5:       return pk(v.s_t4, '0, v.rout_t4, v.alu, 1'b0, 1'b0);
      6:       return pk(v.s_t5, v.rin_t5, '0, '0, 1'b0, 1'b0);
      default: return pk(c_T6, '0, '0, '0, 1'b0, 1'b0);
    endcase
  endfunction

  function automatic logic mr(vec_t v, int k);
    if (k >= 2 && k < 2 + int'(v.wait_n)) return 1'b0;
    if (k == 2 + int'(v.wait_n))          return 1'b1;
    return !v.noise;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Entered at a falling edge with the DUT idle; leaves it idle at a falling edge.
  task automatic apply(input vec_t v, input int idx);
    int dc;
    dc = int'(v.base) + int'(v.wait_n);
    ir = v.ir;
    run = 1'b1;
    mem_ready = !v.noise;
    @(posedge clock);
    for (int k = 1; k <= dc + 1; k++) begin
      #1;
      run = 1'b0;
      mem_ready = mr(v, k);
      @(negedge clock);
      check($sformatf("vec%0d_cyc%0d", idx, k), 64'(word()), 64'(expect_word(v, k)));
      check($sformatf("vec%0d_cyc%0d_rin_rout_excl", idx, k), 64'((Rin != 16'h0) && (Rout != 16'h0)), 64'h0);
      if (k <= dc) @(posedge clock);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // 0x222B8000 decodes as sub ra=4 rb=5 rc=7.
    vecs[0]  = mkv(32'h222B8000,               0, 0, 7, c_T4A, c_T5A, 16'h0020, 16'h0080, 16'h0010, 5'b00100, 0);
    vecs[1]  = mkv(mk(5'b00100, 2, 5, 7),      3, 0, 7, c_T4A, c_T5A, 16'h0020, 16'h0080, 16'h0004, 5'b00100, 0);
    vecs[2]  = mkv(mk(5'b01111, 1, 3, 4),      0, 0, 8, c_T4M, c_T5M, 16'h0008, 16'h0010, 16'h0000, 5'b01111, 0);
    vecs[3]  = mkv(mk(5'b10000, 15, 14, 13),   2, 1, 8, c_T4M, c_T5M, 16'h4000, 16'h2000, 16'h0000, 5'b10000, 0);
    vecs[4]  = mkv(mk(5'b10001, 6, 9, 2),      0, 0, 7, c_T4A, c_T5A, 16'h0200, 16'h0200, 16'h0040, 5'b10001, 0);
    vecs[5]  = mkv(mk(5'b10010, 3, 0, 11),     0, 1, 7, c_T4A, c_T5A, 16'h0001, 16'h0001, 16'h0008, 5'b10010, 0);
    vecs[6]  = mkv(mk(5'b00011, 0, 0, 0),      0, 0, 7, c_T4A, c_T5A, 16'h0001, 16'h0001, 16'h0001, 5'b00011, 0);
    vecs[7]  = mkv(mk(5'b01000, 15, 1, 2),     0, 1, 7, c_T4A, c_T5A, 16'h0002, 16'h0004, 16'h8000, 5'b01000, 0);
    vecs[8]  = mkv(mk(5'b00101, 7, 8, 9),      1, 0, 7, c_T4A, c_T5A, 16'h0100, 16'h0200, 16'h0080, 5'b00101, 0);
    vecs[9]  = mkv(mk(5'b00111, 10, 12, 3),    0, 0, 7, c_T4A, c_T5A, 16'h1000, 16'h0008, 16'h0400, 5'b00111, 0);
    vecs[10] = mkv(mk(5'b11010, 1, 2, 3),      0, 0, 4, '0, '0, '0, '0, '0, '0, 0);
    vecs[11] = mkv(mk(5'b11100, 4, 5, 6),      0, 0, 4, '0, '0, '0, '0, '0, '0, 1);
    vecs[12] = mkv(mk(5'b00000, 9, 9, 9),      2, 0, 4, '0, '0, '0, '0, '0, '0, 1);

    // Reset held with run and mem_ready high.
    clear_n = 1'b0;
    run = 1'b1;
    mem_ready = 1'b1;
    ir = 32'h222B8000;
    @(negedge clock);
    @(negedge clock);
    check("reset_outputs", 64'({word(), bus_err, halted}), 64'h0);
    run = 1'b0;
    clear_n = 1'b1;
    @(negedge clock);
    check("idle_after_reset", 64'({word(), bus_err, halted}), 64'h0);

    for (int i = 0; i < 13; i++) apply(vecs[i], i);

    // Back-to-back with run held, then asynchronous clear in T4 of the second.
    ir = 32'h222B8000;
    run = 1'b1;
    mem_ready = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clock);
      if (k == 7) check("b2b_done_cyc7", 64'(word()), 64'(pk('0, '0, '0, '0, 1'b1, 1'b0)));
      if (k == 8) check("b2b_t0_cyc8", 64'(word()), 64'(pk(c_T0, '0, '0, '0, 1'b0, 1'b0)));
      @(posedge clock);
    end
    #1;
    run = 1'b0;
    check("b2b_t4", 64'(word()), 64'(pk(c_T4A, '0, 16'h0080, 5'b00100, 1'b0, 1'b0)));
    #1;
    clear_n = 1'b0;
    #1;
    check("async_clear_t4", 64'({word(), bus_err, halted}), 64'h0);
    @(negedge clock);
    clear_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      check($sformatf("abort_idle_%0d", k), 64'({word(), bus_err, halted}), 64'h0);
    end

    // HALT opcode: sticky with run held high until clear_n.
    ir = mk(5'b11011, 1, 2, 3);
    run = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      if (k == 1)      check("halt_t0", 64'(word()), 64'(pk(c_T0, '0, '0, '0, 1'b0, 1'b0)));
      else if (k == 2) check("halt_t1", 64'(word()), 64'(pk(c_T1, '0, '0, '0, 1'b0, 1'b0)));
      else if (k == 3) check("halt_t2", 64'(word()), 64'(pk(c_T2, '0, '0, '0, 1'b0, 1'b0)));
      else check($sformatf("halted_%0d", k), 64'({word(), bus_err, halted}), 64'({53'h0, 2'b01}));
      @(posedge clock);
    end
    @(negedge clock);
    clear_n = 1'b0;
    run = 1'b0;
    #1;
    check("halt_cleared", 64'({bus_err, halted}), 64'h0);
    @(negedge clock);
    clear_n = 1'b1;

    // Memory never ready: 15 wait cycles then bus error and halt.
    ir = 32'h222B8000;
    run = 1'b1;
    mem_ready = 1'b0;
    @(posedge clock);
    for (int k = 1; k <= 19; k++) begin
      #1;
      run = 1'b0;
      @(negedge clock);
      if (k == 16)
        check("timeout_last_wait", 64'({word(), bus_err, halted}), 64'({pk(c_T1, '0, '0, '0, 1'b0, 1'b0), 2'b00}));
      if (k >= 17)
        check($sformatf("timeout_halt_%0d", k), 64'({word(), bus_err, halted}), 64'({53'h0, 2'b11}));
      if (k < 19) @(posedge clock);
    end
    @(negedge clock);
    clear_n = 1'b0;
    #1;
    check("bus_err_cleared", 64'({bus_err, halted}), 64'h0);
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
